// File: rtl/sequenceur_compteur.sv
// sequenceur_compteur: control FSM for the 3-digit up/down counter.
// Button pulses and a direction level drive a bounded, signed 12-bit count.
// The count steps once per prescaled tick. maj is a one-cycle strobe for the
// downstream BCD split stage.
//
// Ports
//   count      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   btn_start  in   start/resume pulse
//   btn_stop   in   pause/stop pulse
//   btn_raz    in   clear-to-VAL_MIN pulse
//   btn_load   in   load pulse, samples load_val
//   load_val   in   signed 12-bit preset, clamped to [VAL_MIN, VAL_MAX]
//   dir        in   1 = count up, 0 = count down
//   compteur   out  signed 12-bit count (registered)
//   maj        out  high in the cycle compteur holds a new value
//   etat       out  00 ARRET, 01 COMPTE, 10 DECOMPTE, 11 PAUSE
//   sature     out  value sits at the bound of the running direction (WRAP=0)
//
// state    | meaning
// ARRET    | stopped, prescaler held at 0
// COMPTE   | running upward, prescaler counting
// DECOMPTE | running downward, prescaler counting
// PAUSE    | frozen, prescaler held at 0, start resumes per dir
module sequenceur_compteur #(
  parameter int PRESCALE = 50000000,
  parameter int VAL_MAX  = 999,
  parameter int VAL_MIN  = 0,
  parameter int WRAP     = 0
) (
  input  logic               count,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               btn_stop,
  input  logic               btn_raz,
  input  logic               btn_load,
  input  logic signed [11:0] load_val,
  input  logic               dir,
  output logic signed [11:0] compteur,
  output logic               maj,
  output logic [1:0]         etat,
  output logic               sature
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0]      PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic signed [11:0] MAX_V      = 12'(VAL_MAX);
  localparam logic signed [11:0] MIN_V      = 12'(VAL_MIN);

  typedef enum logic [1:0] {
    ARRET    = 2'b00,
    COMPTE   = 2'b01,
    DECOMPTE = 2'b10,
    PAUSE    = 2'b11
  } etat_t;

  etat_t              state, nxt_state;
  logic [PW-1:0]      presc, nxt_presc;
  logic signed [11:0] nxt_val, load_clamped, step_val;
  logic               running, tick, nxt_sat;

  assign running = (state == COMPTE) || (state == DECOMPTE);
  assign tick    = running && (presc == PRESC_LAST);
  assign etat    = state;

  always_comb begin
    load_clamped = load_val;
    if (load_val > MAX_V)      load_clamped = MAX_V;
    else if (load_val < MIN_V) load_clamped = MIN_V;
  end

  // Value the tick would produce in the current running direction; at a
  // bound it either wraps or holds.
  always_comb begin
    step_val = compteur;
    if (state == COMPTE) begin
      if (compteur >= MAX_V) step_val = (WRAP != 0) ? MIN_V : compteur;
      else                   step_val = compteur + 12'sd1;
    end else begin
      if (compteur <= MIN_V) step_val = (WRAP != 0) ? MAX_V : compteur;
      else                   step_val = compteur - 12'sd1;
    end
  end

  // Commands in priority order: raz > load > stop > start > tick step.
  always_comb begin
    nxt_state = state;
    nxt_val   = compteur;
    nxt_presc = '0;
    if (btn_raz) begin
      nxt_state = ARRET;
      nxt_val   = MIN_V;
    end else if (btn_load) begin
      nxt_val   = load_clamped;
    end else if (btn_stop) begin
      case (state)
        COMPTE, DECOMPTE: nxt_state = PAUSE;
        default:          nxt_state = ARRET;
      endcase
    end else if (btn_start && !running) begin
      nxt_state = dir ? COMPTE : DECOMPTE;
    end else if (running) begin
      if (tick) nxt_val = step_val;
      nxt_presc = tick ? '0 : presc + PW'(1);
      // Direction follows dir while running; the prescaler keeps its phase.
      nxt_state = dir ? COMPTE : DECOMPTE;
    end
  end

  always_comb begin
    nxt_sat = 1'b0;
    if (WRAP == 0) begin
      nxt_sat = ((nxt_state == COMPTE)   && (nxt_val == MAX_V)) ||
                ((nxt_state == DECOMPTE) && (nxt_val == MIN_V));
    end
  end

  always_ff @(posedge count) begin
    if (reset) begin
      state    <= ARRET;
      compteur <= MIN_V;
      presc    <= '0;
      maj      <= 1'b0;
      sature   <= 1'b0;
    end else begin
      state    <= nxt_state;
      compteur <= nxt_val;
      presc    <= nxt_presc;
      maj      <= (nxt_val != compteur);
      sature   <= nxt_sat;
    end
  end

endmodule
